// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the stall/flush controller.
// State encodings and default sizing parameters.
package hazard_stall_ctrl_pkg;

  localparam int MAX_DSTALL_DEF = 3;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_DSTALL = 3'd1,
    ST_MSTALL = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall request inputs and pipeline-register controls.
// master drives the requests, slave is the controller.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hazard;
  logic             imem_stall;
  logic             dmem_stall;
  logic             branch_taken_ex;
  logic             halt_id;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_nop;
  logic             idex_we;
  logic             idex_nop;
  logic             back_we;
  logic             halted;
  logic             stall_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output hazard, imem_stall, dmem_stall,
    output branch_taken_ex, halt_id,
    input  pc_we, ifid_we, ifid_nop,
    input  idex_we, idex_nop, back_we,
    input  halted, stall_err, stall_cycles
  );

  modport slave (
    input  hazard, imem_stall, dmem_stall,
    input  branch_taken_ex, halt_id,
    output pc_we, ifid_we, ifid_nop,
    output idex_we, idex_nop, back_we,
    output halted, stall_err, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl_stall_counter_sat.sv
// Saturating up-counter with synchronous reset.
// Holds at all-ones instead of wrapping.
module stall_counter_sat #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (rst_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipe.
// Mealy controls from inputs and state; registered status.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MAX_DSTALL = MAX_DSTALL_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  hazard_stall_ctrl_if.slave bus
);

  localparam int DW = $clog2(MAX_DSTALL + 1);
  localparam logic [DW-1:0] DMAX = DW'(MAX_DSTALL);

  state_t        state_q, state_d;
  logic          halted_q, halted_d;
  logic          err_q, err_d;
  logic [DW-1:0] dstall_q, dstall_d;

  logic pc_we, ifid_we, ifid_nop;
  logic idex_we, idex_nop, back_we;

  always_comb begin
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    ifid_nop = 1'b0;
    idex_we  = 1'b1;
    idex_nop = 1'b0;
    back_we  = 1'b1;
    state_d  = ST_RUN;
    halted_d = halted_q;
    err_d    = err_q;
    dstall_d = '0;
    if (rst) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      ifid_nop = 1'b1;
      idex_we  = 1'b0;
      idex_nop = 1'b1;
      back_we  = 1'b0;
      halted_d = 1'b0;
      err_d    = 1'b0;
    end else if (state_q == ST_HALT) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_nop = 1'b1;
      back_we  = !bus.dmem_stall;
      state_d  = ST_HALT;
    end else if (bus.dmem_stall) begin
      // Full freeze; the watchdog count survives it.
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      back_we  = 1'b0;
      state_d  = ST_MSTALL;
      dstall_d = dstall_q;
    end else if (bus.branch_taken_ex) begin
      ifid_nop = 1'b1;
      idex_nop = 1'b1;
      state_d  = ST_FLUSH;
    end else if (bus.halt_id) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      state_d  = ST_HALT;
      halted_d = 1'b1;
    end else if (bus.hazard) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_nop = 1'b1;
      state_d  = ST_DSTALL;
      if (dstall_q == DMAX) begin
        err_d    = 1'b1;
        dstall_d = dstall_q;
      end else begin
        dstall_d = dstall_q + 1'b1;
      end
    end else if (bus.imem_stall) begin
      pc_we    = 1'b0;
      ifid_nop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    halted_q <= halted_d;
    err_q    <= err_d;
    dstall_q <= dstall_d;
  end

  stall_counter_sat #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_i (rst),
    .inc_i (!pc_we && !halted_q),
    .cnt_o (bus.stall_cycles)
  );

  assign bus.pc_we     = pc_we;
  assign bus.ifid_we   = ifid_we;
  assign bus.ifid_nop  = ifid_nop;
  assign bus.idex_we   = idex_we;
  assign bus.idex_nop  = idex_nop;
  assign bus.back_we   = back_we;
  assign bus.halted    = halted_q;
  assign bus.stall_err = err_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: directed cycles push expectations,
// a negedge monitor pops and compares.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(16)) bus ();
  hazard_stall_ctrl_if #(.CNT_W(3))  bs ();

  hazard_stall_ctrl #(.MAX_DSTALL(3), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  hazard_stall_ctrl #(.MAX_DSTALL(3), .CNT_W(3)) dut_s (
    .clk (clk), .rst (rst), .bus (bs)
  );

  assign bs.hazard          = bus.hazard;
  assign bs.imem_stall      = bus.imem_stall;
  assign bs.dmem_stall      = bus.dmem_stall;
  assign bs.branch_taken_ex = bus.branch_taken_ex;
  assign bs.halt_id         = bus.halt_id;

  // {rst, hazard, imem, dmem, branch, halt}
  localparam logic [5:0] I_0  = 6'b000000;
  localparam logic [5:0] I_RS = 6'b100000;
  localparam logic [5:0] I_HZ = 6'b010000;
  localparam logic [5:0] I_IM = 6'b001000;
  localparam logic [5:0] I_DM = 6'b000100;
  localparam logic [5:0] I_BR = 6'b000010;
  localparam logic [5:0] I_HT = 6'b000001;

  // {pc_we, ifid_we, ifid_nop, idex_we, idex_nop, back_we}
  localparam logic [5:0] C_RUN = 6'b110101;
  localparam logic [5:0] C_RST = 6'b001010;
  localparam logic [5:0] C_HZ  = 6'b000111;
  localparam logic [5:0] C_BR  = 6'b111111;
  localparam logic [5:0] C_MEM = 6'b000000;
  localparam logic [5:0] C_HID = 6'b000101;
  localparam logic [5:0] C_HST = 6'b000111;
  localparam logic [5:0] C_HDM = 6'b000110;
  localparam logic [5:0] C_IM  = 6'b011101;

  typedef struct packed {
    logic [5:0]  ctl;
    logic        h;
    logic        e;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic drive(input logic [5:0] in);
    rst                 = in[5];
    bus.hazard          = in[4];
    bus.imem_stall      = in[3];
    bus.dmem_stall      = in[2];
    bus.branch_taken_ex = in[1];
    bus.halt_id         = in[0];
  endtask

  task automatic cyc(input logic [5:0] in, input logic [5:0] ctl,
                     input logic h, input logic e, input int cnt);
    exp_t x;
    @(posedge clk);
    #2;
    drive(in);
    x.ctl = ctl;
    x.h   = h;
    x.e   = e;
    x.cnt = 16'(cnt);
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    logic [5:0] act;
    logic [2:0] sat;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        act = {bus.pc_we, bus.ifid_we, bus.ifid_nop,
               bus.idex_we, bus.idex_nop, bus.back_we};
        sat = (x.cnt > 16'd7) ? 3'd7 : x.cnt[2:0];
        n_chk += 4;
        if (act !== x.ctl) begin
          n_err++;
          $display("FAIL ctl t=%0t got %b want %b", $time, act, x.ctl);
        end
        if ({bus.halted, bus.stall_err} !== {x.h, x.e}) begin
          n_err++;
          $display("FAIL status t=%0t got h%b e%b want h%b e%b",
                   $time, bus.halted, bus.stall_err, x.h, x.e);
        end
        if (bus.stall_cycles !== x.cnt) begin
          n_err++;
          $display("FAIL stall_cycles t=%0t got %0d want %0d",
                   $time, bus.stall_cycles, x.cnt);
        end
        if (bs.stall_cycles !== sat) begin
          n_err++;
          $display("FAIL sat_cycles t=%0t got %0d want %0d",
                   $time, bs.stall_cycles, sat);
        end
      end
    end
  end

  initial begin : stim
    drive(I_RS);
    repeat (2) @(posedge clk);
    // reset state, then idle
    cyc(I_RS, C_RST, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(I_0, C_RUN, 0, 0, 0);
    // two-cycle data stall
    cyc(I_HZ, C_HZ, 0, 0, 0);
    cyc(I_HZ, C_HZ, 0, 0, 1);
    cyc(I_0, C_RUN, 0, 0, 2);
    cyc(I_0, C_RUN, 0, 0, 2);
    // watchdog trips on the fourth stall cycle
    for (int i = 0; i < 4; i++) cyc(I_HZ, C_HZ, 0, 0, 2 + i);
    cyc(I_0, C_RUN, 0, 1, 6);
    cyc(I_0, C_RUN, 0, 1, 6);
    cyc(I_RS, C_RST, 0, 1, 6);
    cyc(I_0, C_RUN, 0, 0, 0);
    // branch squashes hazard, then flush cycle
    cyc(I_HZ | I_BR, C_BR, 0, 0, 0);
    cyc(I_0, C_RUN, 0, 0, 0);
    cyc(I_0, C_RUN, 0, 0, 0);
    // dmem freeze preserves the watchdog count
    cyc(I_HZ, C_HZ, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(I_HZ | I_DM, C_MEM, 0, 0, 1 + i);
    cyc(I_HZ, C_HZ, 0, 0, 4);
    cyc(I_HZ, C_HZ, 0, 0, 5);
    cyc(I_HZ, C_HZ, 0, 0, 6);
    cyc(I_0, C_RUN, 0, 1, 7);
    // imem stall, dmem over branch
    cyc(I_IM, C_IM, 0, 1, 7);
    cyc(I_0, C_RUN, 0, 1, 8);
    cyc(I_DM | I_BR, C_MEM, 0, 1, 8);
    cyc(I_0, C_RUN, 0, 1, 9);
    // halt is sticky until reset
    cyc(I_HT, C_HID, 0, 1, 9);
    cyc(I_0, C_HST, 1, 1, 10);
    cyc(I_DM, C_HDM, 1, 1, 10);
    cyc(I_HZ | I_BR, C_HST, 1, 1, 10);
    cyc(I_0, C_HST, 1, 1, 10);
    cyc(I_RS, C_RST, 1, 1, 10);
    cyc(I_0, C_RUN, 0, 0, 0);
    cyc(I_0, C_RUN, 0, 0, 0);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline stall/flush controller for the 5-stage processor.
- Consumes the source-register hazard match from the decode-stage hazard address check, plus memory-busy, branch-redirect and halt indications.
- Produces write-enable and bubble/flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Tracks stall state: data-stall length watchdog, sticky halt, saturating stall-cycle performance counter.

Parameters:
- MAX_DSTALL, 3: maximum consecutive data-stall cycles. There are 3 writer stages downstream of ID, so a longer stall indicates a hazard-logic fault.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  input  1  system clock. All state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- hazard  input  1  RAW match for the instruction in ID (output of the 2-source hazard check).
- imem_stall  input  1  instruction memory not ready this cycle.
- dmem_stall  input  1  data memory busy; the whole pipe must freeze.
- branch_taken_ex  input  1  branch/jump resolved taken in EX; redirect this cycle.
- halt_id  input  1  HALT instruction decoded in ID.
- pc_we  output  1  PC write enable.
- ifid_we  output  1  IF/ID write enable.
- ifid_nop  output  1  load NOP into IF/ID (takes effect only when ifid_we=1).
- idex_we  output  1  ID/EX write enable.
- idex_nop  output  1  load bubble into ID/EX (takes effect only when idex_we=1).
- back_we  output  1  EX/MEM and MEM/WB write enable.
- halted  output  1  registered, sticky halt status.
- stall_err  output  1  registered, sticky watchdog error.
- stall_cycles  output  CNT_W  saturating count of cycles with pc_we=0 while not halted.

Behaviour:
- Reset: one clock, synchronous active-high reset named rst, clock named clk. While rst=1:
  - pc_we=ifid_we=idex_we=back_we=0, ifid_nop=idex_nop=1.
  - At the edge: state<=RUN, halted<=0, stall_err<=0, stall_cycles<=0, dstall_cnt<=0.
  - Reset mid-stall or mid-halt returns to RUN with no residue.
- Registered state: RUN, DSTALL, MSTALL, FLUSH, HALT. Output controls are combinational from current inputs and state (Mealy), so a stall acts in the same cycle the hazard is detected. Zero added latency.
- Per-cycle priority, highest first. Defaults: all we=1, all nop=0.
  1. HALT state: pc_we=0, ifid_we=0, idex_we=1 with idex_nop=1, back_we=!dmem_stall. Exit only by rst.
  2. dmem_stall: pc_we=ifid_we=idex_we=back_we=0. Next state MSTALL. Dominates branch, halt and hazard, which are re-evaluated once dmem_stall drops.
  3. branch_taken_ex: pc_we=1, ifid_nop=1, idex_nop=1. Next state FLUSH, then RUN on the following cycle unless another condition applies. Squashes any coincident hazard or halt_id, since the ID instruction is wrong-path.
  4. halt_id: pc_we=0, ifid_we=0, idex passes the HALT normally. Next state HALT; halted<=1.
  5. hazard: pc_we=0, ifid_we=0, idex_nop=1. Next state DSTALL.
  6. imem_stall: pc_we=0, ifid_nop=1. Downstream runs.
  7. Otherwise: run. Next state RUN.
- Data-stall watchdog:
  - dstall_cnt increments on each cycle the hazard rule (5) is applied and clears on any cycle it is not.
  - dstall_cnt holds (does not clear) during dmem_stall cycles.
  - If hazard is applied while dstall_cnt==MAX_DSTALL, stall_err<=1 (sticky) and the stall continues.
- stall_cycles:
  - Increments at the edge when pc_we=0 and halted=0.
  - Saturates at all-ones; no wrap.
- Simultaneous inputs resolve only by the priority list above. No combination produces pc_we=1 together with ifid_we=0.

Decomposition:
- Shared pipeline package/include holds:
  - State encodings ST_RUN=0, ST_DSTALL=1, ST_MSTALL=2, ST_FLUSH=3, ST_HALT=4 (3 bits).
  - MAX_DSTALL and CNT_W defaults.
- One sub-module: stall_counter_sat. It is the CNT_W-bit saturating counter built on the codebase dff cells, with inc and synchronous rst inputs.
- The FSM next-state and output logic stays in hazard_stall_ctrl.

Test Plan:
1. Reset, then idle with all inputs 0 -> pc_we=ifid_we=idex_we=back_we=1, nops=0, stall_cycles stays 0 after 10 cycles.
2. hazard=1 for 2 cycles -> pc_we=0, ifid_we=0, idex_nop=1 both cycles. stall_cycles=2, stall_err=0. Cycle 3 returns to run.
3. hazard held 4 cycles -> stall_err rises after the 4th edge and stays 1 after hazard drops. Only rst clears it.
4. hazard=1 and branch_taken_ex=1 in the same cycle -> pc_we=1, ifid_nop=1, idex_nop=1. Next cycle in FLUSH with no stall. stall_cycles unchanged.
5. dmem_stall=1 for 3 cycles with hazard=1 -> all we=0 for 3 cycles, dstall_cnt preserved. After dmem_stall drops, the data stall resumes.
6. halt_id=1 -> halted=1 next cycle, pc_we=0 indefinitely. rst=1 for 1 cycle -> halted=0, state RUN. Separately, force stall_cycles to 0xFFFF -> stays at 0xFFFF on a further stall.
